// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared fetch-side types and constants for the segmented core
package pc_redirect_unit_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
    localparam int CORE_XLEN = 32;
    localparam int PC_STEP   = 4;
endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// pc_redirect_unit_sat_counter: CNT_W-bit counter that increments on i_en and sticks at all-ones
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : increment request
//   o_cnt          : current count
module pc_redirect_unit_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= (i_en && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, applies MEM-stage redirects, squashes wrong-path slots
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_mem_valid         : EX/MEM slot holds a real instruction
//   i_taken, i_target   : jump controller decision and redirect target
//   i_stall             : load-use stall (freeze PC)
//   i_imem_ready        : instruction memory accepts fetch this cycle
//   o_pc, o_fetch_valid : fetch request
//   o_flush_*           : squash pipeline registers on next edge (same cycle as redirect)
//   o_misaligned        : sticky, set by a redirect to a non word-aligned target
//   o_taken_cnt         : accepted redirects (saturating)
//   o_stall_cnt         : cycles fetch was held in RUN (saturating)
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int          XLEN     = CORE_XLEN,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mem_valid,
    input  logic             i_taken,
    input  logic [XLEN-1:0]  i_target,
    input  logic             i_stall,
    input  logic             i_imem_ready,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_fetch_valid,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_flush_ex_mem,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);
    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_misaligned;
    logic            w_run;
    logic            w_redirect;
    logic            w_bad_tgt;
    logic            w_hold;

    assign w_run      = (r_state == RUN);
    assign w_redirect = w_run & i_mem_valid & i_taken;
    assign w_bad_tgt  = |i_target[1:0];
    // Redirect overrides a held fetch: imem is stateless, so abandoning the request is safe.
    assign w_hold     = i_stall | ~i_imem_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= BOOT;
            r_pc          <= XLEN'(RESET_PC);
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (w_redirect) begin
                        // Misaligned target still loads the PC so debug can see it.
                        r_pc <= i_target;
                        if (w_bad_tgt) begin
                            r_state       <= HALT;
                            r_fetch_valid <= 1'b0;
                            r_misaligned  <= 1'b1;
                        end
                    end else if (!w_hold) begin
                        r_pc <= r_pc + XLEN'(PC_STEP);
                    end
                end
                default: r_fetch_valid <= 1'b0;
            endcase
        end
    end

    assign o_pc           = r_pc;
    assign o_fetch_valid  = r_fetch_valid;
    assign o_misaligned   = r_misaligned;
    assign o_flush_if_id  = w_redirect;
    assign o_flush_id_ex  = w_redirect;
    assign o_flush_ex_mem = w_redirect;

    pc_redirect_unit_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_redirect & ~w_bad_tgt),
        .o_cnt   (o_taken_cnt)
    );

    pc_redirect_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_run & ~w_redirect & w_hold),
        .o_cnt   (o_stall_cnt)
    );
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the MEM-stage branch/jump decision in the segmented RISC-V core.
- Owns the PC register and fetch request (valid/ready handshake to instruction memory).
- Applies redirects from the jump controller and squashes wrong-path instructions in IF/ID, ID/EX and EX/MEM.
- Enters a sticky halt on a misaligned target and keeps redirect/flush statistics counters.

Parameters:
XLEN, 32, PC/target width
RESET_PC, 32'h0000_0000, first fetch address after reset
CNT_W, 16, width of statistics counters

Ports:
CLK  in  1  core clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
mem_valid_i  in  1  EX/MEM slot holds a real (non-bubble) instruction
taken_i  in  1  jump controller decision: branch/jump taken (MEM stage)
target_i  in  XLEN  redirect target (EX/MEM ALU result)
stall_i  in  1  load-use stall from hazard unit (freeze PC)
imem_ready_i  in  1  instruction memory accepts fetch this cycle
pc_o  out  XLEN  current fetch address
fetch_valid_o  out  1  fetch request valid
flush_if_id_o  out  1  squash IF/ID on next edge
flush_id_ex_o  out  1  squash ID/EX on next edge
flush_ex_mem_o  out  1  squash EX/MEM on next edge
misaligned_o  out  1  sticky: redirect target had target_i[1:0] != 0
taken_cnt_o  out  CNT_W  accepted redirects
stall_cnt_o  out  CNT_W  cycles with fetch held (stall_i or !imem_ready_i in RUN)

Behaviour:
- Reset (async, RESET_N=0): state=BOOT, pc_o=RESET_PC, fetch_valid_o=0, all flush outputs 0, misaligned_o=0, both counters 0.
- FSM states:
  - BOOT: exactly one cycle, fetch_valid_o=0, then RUN.
  - RUN: fetch_valid_o=1.
  - HALT: fetch_valid_o=0; exited only by reset.
- redirect = mem_valid_i & taken_i, evaluated only in RUN. It is ignored in BOOT and HALT.
- Flush outputs are combinational (Mealy): all three equal redirect in the same cycle. Zero latency, so the wrong-path instructions are squashed on the same edge that loads the new PC.
- In RUN with redirect and target_i[1:0]==0:
  - pc <= target_i; taken_cnt++.
  - Redirect overrides both stall_i and !imem_ready_i. An abandoned fetch is allowed; imem is synchronous and stateless.
- In RUN with redirect and target_i[1:0]!=0:
  - Flushes asserted; misaligned_o <= 1; state <= HALT.
  - pc <= target_i (exposed for debug); taken_cnt unchanged.
- In RUN without redirect:
  - If stall_i=1 or imem_ready_i=0: pc held; stall_cnt++.
  - Otherwise: pc <= pc + 4; wraps modulo 2^XLEN with no flag.
- Handshake rule: pc_o is stable while fetch_valid_o & !imem_ready_i unless a redirect occurs.
- Counters saturate at all-ones; they do not wrap.
- Simultaneous redirect and stall: redirect wins, stall_cnt not incremented.
- Reset asserted mid-operation: immediate return to reset values regardless of state; no partial flush is held.

Decomposition:
- Shared package (core_pkg):
  - typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t
  - localparam PC_STEP = 4
  - XLEN, shared with the segmented_interface wiring
- One natural sub-module: sat_counter (CNT_W-bit saturating incrementer, enable input, async active-low reset). Instantiated twice.
- A wiring designator connects the segmented_interface: the jump controller's taken/target into this block, and the flush outputs onto the pipeline-register wiring.

Test Plan:
- Reset release, imem_ready_i=1, no redirect → cycle 0 fetch_valid_o=0, pc_o=0. Then pc_o = 0, 4, 8, 12 on successive cycles; stall_cnt_o=0.
- At pc_o=0x10, pulse mem_valid_i=1, taken_i=1, target_i=0x40 for 1 cycle:
  - Same cycle: all three flushes = 1.
  - Next cycle: pc_o=0x40, flushes 0, taken_cnt_o=1.
  - Following cycle: pc_o=0x44.
- stall_i=1 for 3 cycles at pc_o=0x20 → pc_o held at 0x20, stall_cnt_o=3. A redirect to 0x80 during the stall → pc_o=0x80 next cycle, stall_cnt_o unchanged that cycle.
- taken_i=1 with mem_valid_i=0 → no flush, pc advances by 4, taken_cnt_o unchanged.
- Redirect to 0x42 → flushes pulse, misaligned_o=1, fetch_valid_o=0 from next cycle. Subsequent valid redirects ignored; RESET_N low clears all state.
- Preload by forcing 2^CNT_W−1 redirects (or CNT_W=2 build, 5 redirects) → taken_cnt_o saturates at 3. pc_o=0xFFFF_FFFC with no redirect → next pc_o=0x0.
